// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and the writeback entry type for the register file front end.
package regfile_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_buffer_wb_fifo.sv
// wb_fifo: in-order entry storage with head/tail pointers; exposes every slot for forwarding.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output wb_entry_t       entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PW-1:0]   head,
    output logic [CW-1:0]   count
);
    logic [PW-1:0] tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: a slot is only observed while valid marks it pending.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= push_entry;
    end

    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, PW'(i) - head} < count;
    end
endmodule

// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: queues writeback requests ahead of the single register file write port
// and forwards pending values onto both read ports.
module regfile_wb_buffer
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wb_hold,
    output logic [ADDR_W-1:0] rf_DstReg,
    output logic              rf_WriteReg,
    output logic [DATA_W-1:0] rf_DstData,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [DATA_W-1:0] RfData1,
    input  logic [DATA_W-1:0] RfData2,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);
    wb_entry_t        entries [DEPTH];
    wb_entry_t        in_entry;
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    head;
    logic             push;
    logic [ADDR_W-1:0] src [2];
    logic [DATA_W-1:0] rfd [2];
    logic [DATA_W-1:0] fwd [2];

    assign empty       = count == '0;
    assign full        = count == CW'(DEPTH);
    assign in_ready    = !full;
    // Writes to R0 complete the handshake but never occupy a slot.
    assign push        = in_valid && in_ready && in_reg != ZERO_REG;
    assign in_entry    = '{dst: in_reg, data: in_data};
    assign rf_WriteReg = !empty && !wb_hold;
    assign rf_DstReg   = empty ? '0 : entries[head].dst;
    assign rf_DstData  = empty ? '0 : entries[head].data;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (in_entry),
        .pop        (rf_WriteReg),
        .entries    (entries),
        .valid      (valid),
        .head       (head),
        .count      (count)
    );

    assign src[0]   = SrcReg1;
    assign src[1]   = SrcReg2;
    assign rfd[0]   = RfData1;
    assign rfd[1]   = RfData2;
    assign SrcData1 = fwd[0];
    assign SrcData2 = fwd[1];

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd[p] = src[p] == ZERO_REG ? '0 : rfd[p];
            for (int k = 0; k < DEPTH; k++)
                if (src[p] != ZERO_REG && valid[head + PW'(k)] && entries[head + PW'(k)].dst == src[p])
                    fwd[p] = entries[head + PW'(k)].data;
        end
    end
endmodule

// File: doc/regfile_wb_buffer.md
# regfile_wb_buffer

Write-side front end for the 16 x 16-bit register file. It accepts writeback requests from the pipeline over a valid/ready handshake and queues them in a small in-order buffer. It drains one entry per cycle into the register file's single write port (DstReg/WriteReg/DstData). It also forwards queued-but-unwritten values onto both read ports, so readers always see the youngest value. It sits between the writeback stage and the register file.

## Interface
- DEPTH, 4, number of queued writeback entries (power of two, >= 2)
- DATA_W, 16, register data width
- ADDR_W, 4, register index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  writeback request valid
- in_ready  out  1  buffer can accept a request
- in_reg  in  ADDR_W  destination register index
- in_data  in  DATA_W  destination data
- wb_hold  in  1  1 = do not drain this cycle (write port borrowed)
- rf_DstReg  out  ADDR_W  to register file DstReg
- rf_WriteReg  out  1  to register file WriteReg
- rf_DstData  out  DATA_W  to register file DstData
- SrcReg1, SrcReg2  in  ADDR_W  read indices (also driven to the register file)
- RfData1, RfData2  in  DATA_W  raw register file read data
- SrcData1, SrcData2  out  DATA_W  forwarded read data
- count  out  $clog2(DEPTH)+1  entries pending
- empty, full  out  1  count==0, count==DEPTH

## Operation
- Push: in_valid && in_ready at an edge. in_ready = !full; it does not depend on a same-cycle pop.
- in_reg == 0 is accepted (handshake completes) and then dropped. No entry is created and count is unchanged. R0 is architecturally zero.
- Pop: rf_WriteReg = !empty && !wb_hold. The head entry is removed at the same edge the register file captures it.
- rf_DstReg and rf_DstData show the head entry when !empty. Both are 0 when empty.
- A push and a pop in the same cycle leave count unchanged. Entries drain strictly in arrival (FIFO) order. Pointers wrap modulo DEPTH.
- Forwarding, per read port, is combinational:
  - SrcRegN == 0: SrcDataN = 0.
  - Otherwise, if any pending entry (head included) matches SrcRegN, output the youngest matching entry's data.
  - Otherwise, output RfDataN.
- A same-cycle incoming request (in_valid) is NOT forwarded. It becomes visible in the cycle after its push edge.
- Duplicate destinations may coexist in the buffer. All are written in order, so the final register value is the youngest.

## Timing
- Reset, while rst is low, asynchronous:
  - count = 0, pointers = 0, empty = 1, full = 0, in_ready = 1.
  - rf_WriteReg = 0, rf_DstReg = 0, rf_DstData = 0.
  - SrcDataN = RfDataN (or 0 for R0).
- Reset mid-operation discards all pending entries. None are written.
- Latency: a request pushed at edge N into an empty, unheld buffer drives rf_WriteReg = 1 during cycle N+1. The register file writes it at edge N+1. It is forwarded to readers during cycle N+1.
- wb_hold stalls draining only. Pushes continue until full.
- Full: in_ready = 0. A pop in that cycle frees a slot, and in_ready = 1 the next cycle.
- All outputs except SrcDataN derive only from registered state, plus wb_hold for rf_WriteReg. SrcDataN is combinational from SrcRegN/RfDataN and registered state.

## Structure
- Shared package regfile_pkg:
  - DATA_W, ADDR_W, ZERO_REG = 0.
  - typedef wb_entry_t {reg index, data}.
- Sub-module wb_fifo: DEPTH-entry storage, head/tail pointers, count. Exposes all entries plus a per-slot valid vector for forwarding.
- Top level: handshake, R0 drop, write-port drive, and the two forward comparators with youngest-match priority.

## Test plan
- Reset, then push (R3, 0x1234) with no hold: in_ready = 1 after reset. Cycle after push: rf_WriteReg = 1, rf_DstReg = 3, rf_DstData = 0x1234. With SrcReg1 = 3 and RfData1 = 0x0000, SrcData1 = 0x1234. Next cycle empty = 1.
- wb_hold = 1, push (R5, 0x0001), (R5, 0x0002), (R7, 0xBEEF), (R1, 0xFFFF): full = 1, in_ready = 0. SrcReg2 = 5 gives 0x0002. Release hold: four writes in order on consecutive cycles (5, 5, 7, 1), and count decrements 4→0.
- Push (R0, 0xAAAA): handshake completes, count stays 0, rf_WriteReg stays 0. SrcReg1 = 0 gives SrcData1 = 0 even if RfData1 = 0x5555.
- Full buffer with hold released and in_valid held high: pop at edge N. in_ready rises in cycle N+1, and the push completes at edge N+1. Order is preserved across pointer wrap (DEPTH + 3 total pushes, all written in order).
- Three entries pending, assert rst low asynchronously mid-cycle: rf_WriteReg drops to 0 immediately, and count = 0. After release no pending entries are ever written, and SrcData1 = RfData1.
